// File: rtl/dot_prod_out_serializer.sv
// dot_prod_out_serializer
//   Captures the packed result vector from the dot-product engine on the
//   rising edge of dataReady and streams its NROW signed elements, one per
//   valid/ready transfer, to downstream logic. One active vector and one
//   pending vector are held so back-to-back results survive a stalled sink.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   dataReady     result-valid strobe (edge-detected)
//   outputVector  packed result, element k at [k*BITWIDTH +: BITWIDTH]
//   outReady      downstream accepts an element this cycle
//   dataOut       current signed element
//   dataValid     dataOut/dataIndex valid
//   dataIndex     element index of dataOut
//   lastOut       dataValid on the final element of a vector
//   busy          active or pending vector held
//   overrun       sticky: a result vector was dropped
module dot_prod_out_serializer #(
  parameter int NROW            = 16,
  parameter int QN              = 6,
  parameter int QM              = 11,
  parameter int BITWIDTH        = QN + QM + 1,
  parameter int MEMORY_BITWIDTH = BITWIDTH * NROW,
  parameter int ADDR_BITWIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dataReady,
  input  logic [MEMORY_BITWIDTH-1:0] outputVector,
  input  logic                       outReady,
  output logic signed [BITWIDTH-1:0] dataOut,
  output logic                       dataValid,
  output logic [ADDR_BITWIDTH-1:0]   dataIndex,
  output logic                       lastOut,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(NROW - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state, state_n;
  logic [MEMORY_BITWIDTH-1:0] act_buf, act_n;
  logic [MEMORY_BITWIDTH-1:0] pend_buf, pend_n;
  logic                       pend_full, pend_full_n;
  logic [ADDR_BITWIDTH-1:0]   idx_n;
  logic                       overrun_n;
  logic                       dr_q;
  logic                       capture, transfer, at_last;

  assign capture   = dataReady && !dr_q;
  assign dataValid = (state == SEND);
  assign at_last   = (dataIndex == LAST_IDX);
  assign transfer  = dataValid && outReady;
  assign lastOut   = dataValid && at_last;
  assign busy      = dataValid || pend_full;
  // Registered buffer muxed by registered index: no path from outReady.
  assign dataOut   = act_buf[BITWIDTH*int'(dataIndex) +: BITWIDTH];

  always_comb begin
    state_n     = state;
    act_n       = act_buf;
    pend_n      = pend_buf;
    pend_full_n = pend_full;
    idx_n       = dataIndex;
    overrun_n   = overrun;
    case (state)
      IDLE: begin
        if (capture) begin
          act_n   = outputVector;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (transfer && at_last) begin
          // End of vector: refill active from pending or a same-cycle
          // capture so the stream continues without a bubble.
          idx_n = '0;
          if (pend_full) begin
            act_n = pend_buf;
            if (capture) pend_n = outputVector;
            else         pend_full_n = 1'b0;
          end else if (capture) begin
            act_n = outputVector;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (transfer) idx_n = dataIndex + ADDR_BITWIDTH'(1);
          if (capture) begin
            if (!pend_full) begin
              pend_n      = outputVector;
              pend_full_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      act_buf   <= '0;
      pend_buf  <= '0;
      pend_full <= 1'b0;
      dataIndex <= '0;
      overrun   <= 1'b0;
      dr_q      <= 1'b0;
    end else begin
      state     <= state_n;
      act_buf   <= act_n;
      pend_buf  <= pend_n;
      pend_full <= pend_full_n;
      dataIndex <= idx_n;
      overrun   <= overrun_n;
      dr_q      <= dataReady;
    end
  end

endmodule
